// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Bits strictly below idx set; callers truncate to their own width.
  function automatic logic [63:0] low_mask(input logic [5:0] idx);
    return (64'd1 << idx) - 64'd1;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder, N-wide.
module prio_enc_n #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx = '0;
    // Ascending scan so the highest set bit is the last one written.
    for (int k = 0; k < N; k++) begin
      if (req[k]) idx = W'(k);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter: fixed (highest index) or round-robin priority, grant held
// until release, optional forced release after MAX_HOLD cycles.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 16,
  parameter int MAX_HOLD = 0,
  localparam int W       = $clog2(N),
  localparam int CW      = $clog2(MAX_HOLD + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         rr_en_i,
  input  logic         release_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         grant_valid_o,
  output logic         timeout_o
);

  // CW is 0 when the timeout is disabled; keep a 1-bit counter regardless.
  localparam int CWI         = (CW < 1) ? 1 : CW;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam bit HOLD_EN     = (MAX_HOLD > 0);

  arb_state_e     state, state_n;
  logic [W-1:0]   last_idx, last_n;
  logic [CWI-1:0] hold_cnt, hold_n;
  logic [W-1:0]   idx_n;
  logic           valid_n, timeout_n;
  logic [N-1:0]   grant_n;

  logic [N-1:0]   low, masked;
  logic [W-1:0]   m_idx, u_idx, pick_idx;
  logic           m_vld, u_vld;
  logic           timeout_hit, rel;

  assign low    = N'(low_mask(6'(last_idx)));
  assign masked = req_i & low;

  prio_enc_n #(.N(N)) u_enc_masked (.req(masked), .idx(m_idx), .valid(m_vld));
  prio_enc_n #(.N(N)) u_enc_full   (.req(req_i),  .idx(u_idx), .valid(u_vld));

  // Round-robin rotates downward: prefer anything below the last winner, else wrap.
  assign pick_idx    = (rr_en_i && m_vld) ? m_idx : u_idx;
  assign timeout_hit = HOLD_EN && (hold_cnt == CWI'(HOLD_LAST_I)) && !release_i;
  assign rel         = release_i || timeout_hit;

  always_comb begin
    state_n   = state;
    idx_n     = grant_idx_o;
    valid_n   = grant_valid_o;
    last_n    = last_idx;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (u_vld) begin
          state_n = ARB_BUSY;
          idx_n   = pick_idx;
          valid_n = 1'b1;
          last_n  = pick_idx;
          hold_n  = '0;
        end
      end
      ARB_BUSY: begin
        if (rel) begin
          timeout_n = timeout_hit;
          hold_n    = '0;
          if (u_vld) begin
            idx_n  = pick_idx;
            last_n = pick_idx;
          end else begin
            state_n = ARB_IDLE;
            idx_n   = '0;
            valid_n = 1'b0;
          end
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
    grant_n = valid_n ? (N'(1) << idx_n) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= ARB_IDLE;
      grant_o       <= '0;
      grant_idx_o   <= '0;
      grant_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      last_idx      <= '0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_n;
      grant_o       <= grant_n;
      grant_idx_o   <= idx_n;
      grant_valid_o <= valid_n;
      timeout_o     <= timeout_n;
      last_idx      <= last_n;
      hold_cnt      <= hold_n;
    end
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
Parametrised successor to the team's 16-input combinational priority encoder. Arbitrates N requesters for a shared resource and registers a one-hot grant plus its encoded index. Supports fixed priority (highest index wins) or round-robin mode, holds a grant until release, and can force release after a hold timeout. Sits between request sources and a shared bus or port.

Parameters:
N, 16, number of requesters (2..64)
W, $clog2(N), index width (derived, not overridden)
MAX_HOLD, 0, max cycles a grant may be held; 0 disables the timeout
CW, $clog2(MAX_HOLD+1), hold counter width (derived)

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_ni  input  1  synchronous active-low reset
req_i  input  N  request vector; bit k is requester k
rr_en_i  input  1  1 = round-robin, 0 = fixed priority (highest index wins)
release_i  input  1  current holder is done; sampled only while busy
grant_o  output  N  registered one-hot grant
grant_idx_o  output  W  registered index of grant_o; 0 when no grant
grant_valid_o  output  1  registered; 1 while a grant is held
timeout_o  output  1  registered one-cycle pulse on forced release

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low on rst_ni. While rst_ni=0 at an edge: state=IDLE, grant_o=0, grant_idx_o=0, grant_valid_o=0, timeout_o=0, last_idx=0, hold_cnt=0. Reset overrides a grant in progress; there is no release handshake.
- States: IDLE (no grant) and BUSY (grant held).
- Arbitration function, evaluated combinationally from req_i, rr_en_i and last_idx:
  - Fixed mode: choose the highest set bit of req_i.
  - RR mode: masked = req_i & ((1<<last_idx)-1). If masked != 0, choose the highest set bit of masked; otherwise choose the highest set bit of req_i.
  - Priority therefore rotates downward and wraps. With last_idx=0 after reset, RR mode behaves like fixed mode for the first grant.
- IDLE: if req_i != 0, go to BUSY at the next edge with the chosen grant, so latency is 1 cycle from request to grant. Load last_idx with the chosen index and clear hold_cnt. If req_i = 0, stay in IDLE.
- BUSY: the grant is stable; changes on req_i are ignored, including the holder dropping its request.
  - release_i=1: re-arbitrate in the same cycle. If req_i != 0, load the new grant at the next edge with no bubble. In fixed mode the same index may be granted again. If req_i = 0, go to IDLE and clear the grant outputs.
  - Forced release: if MAX_HOLD>0, hold_cnt==MAX_HOLD-1 and release_i=0, treat the cycle as a release. timeout_o=1 for exactly the one cycle in which the new grant (or IDLE) appears.
  - If release_i=1 and the timeout condition hold in the same cycle, it is a normal release and timeout_o stays 0.
  - Otherwise increment hold_cnt. hold_cnt saturates and never wraps.
- A change on rr_en_i takes effect at the next arbitration. last_idx is updated in both modes.
- grant_o is always one-hot or zero, and grant_o == (grant_valid_o ? 1<<grant_idx_o : 0).

Decomposition:
- Package arb_pkg holds the state enum (ARB_IDLE, ARB_BUSY) and a helper function for the low-bit mask.
- Sub-module prio_enc_n (parameter N): combinational highest-set-bit encoder with outputs idx and valid, the N-wide generalisation of the 16-bit encoder. The arbiter instantiates it twice, once for the masked vector and once for the unmasked vector.

Test Plan:
1. Reset: hold rst_ni=0 for 3 cycles with req_i=16'hFFFF -> all outputs 0. Release reset -> one cycle later grant_idx_o=15, grant_o=16'h8000, grant_valid_o=1.
2. Fixed mode: rr_en_i=0, req_i=16'h0012 -> idx 4. Pulse release_i with req unchanged -> idx 4 again on the next cycle, grant_valid_o never drops.
3. RR rotation: rr_en_i=1, req_i=16'hFFFF, release_i held at 1 -> grant_idx_o sequence 15,14,...,1,0,15 on consecutive cycles.
4. RR wrap/skip: rr_en_i=1, req_i=16'h8001 after reset, release each cycle -> 15,0,15,0.
5. Timeout: MAX_HOLD=8, req_i=16'h0004, release_i=0 -> idx 2 held 8 cycles, timeout_o pulses once, idx 2 regranted. Repeat with release_i=1 on the 8th cycle -> no timeout_o pulse.
6. Release to idle and mid-reset: release with req_i=0 -> grant_valid_o=0 next cycle, state IDLE. Assert rst_ni=0 during BUSY -> grant cleared at that edge.
